// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation controller status display: digit count,
// status codes, active-low glyph table and the scan slot states.
package rega_pkg;
    localparam int NDIG = 4;

    localparam logic [2:0] COD_BLANK = 3'd0;
    localparam logic [2:0] COD_L     = 3'd1;
    localparam logic [2:0] COD_H     = 3'd2;
    localparam logic [2:0] COD_A     = 3'd3;
    localparam logic [2:0] COD_E     = 3'd4;
    localparam logic [2:0] COD_P     = 3'd5;
    localparam logic [2:0] COD_U     = 3'd6;
    localparam logic [2:0] COD_DASH  = 3'd7;

    // {g,f,e,d,c,b,a}, active-low, indexed by status code
    localparam logic [6:0] GLYPH [0:7] = '{7'h7F, 7'h47, 7'h09, 7'h08,
                                           7'h06, 7'h0C, 7'h41, 7'h3F};

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } slot_e;
endpackage

// File: rtl/mostrador_prescaler.sv
// Digit-slot prescaler: counts 0..PRESC-1 and flags the last count of each slot.
module mostrador_prescaler #(
    parameter int PRESC = 50000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);
    localparam int W = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [W-1:0] cnt_q;

    assign TICK = (cnt_q == W'(PRESC - 1));

    always_ff @(posedge CLK) begin
        if (RST)       cnt_q <= '0;
        else if (TICK) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/mostrador_varredura.sv
// Time-multiplexed 4-digit 7-segment driver with LOAD/ACK update, frame-aligned
// commit, per-digit blink and decimal point. All outputs are registered, active-low.
module mostrador_varredura
    import rega_pkg::*;
#(
    parameter int PRESC        = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] CODES,
    input  logic [3:0]  BLINK,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    output logic        ACK,
    output logic        FRAME,
    output logic [6:0]  SEGs,
    output logic        SEG_P,
    output logic        SEG_D1,
    output logic        SEG_D2,
    output logic        SEG_D3,
    output logic        SEG_D4
);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic tick;

    mostrador_prescaler #(.PRESC(PRESC)) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    slot_e       state_q;
    logic [1:0]  idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic        phase_q, phase_d;
    logic        pend_q, pend_d;
    logic [11:0] sh_codes_q, act_codes_q, act_codes_d;
    logic [3:0]  sh_blink_q, act_blink_q, act_blink_d;
    logic [3:0]  sh_dp_q, act_dp_q, act_dp_d;
    logic [6:0]  seg_q, seg_d;
    logic        segp_q, segp_d;
    logic [3:0]  dig_q;
    logic        ack_q, frame_q;
    logic        commit, accept, blanked;
    logic [2:0]  code_n;

    // Next-slot values: a commit is visible in the very S_BLANK it opens, and a
    // commit frees the shadow so an offer in the same cycle is taken.
    always_comb begin
        commit      = tick && (idx_q == 2'(NDIG - 1));
        accept      = LOAD && (!pend_q || commit);
        pend_d      = accept ? 1'b1 : (commit ? 1'b0 : pend_q);
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        act_codes_d = commit ? sh_codes_q : act_codes_q;
        act_blink_d = commit ? sh_blink_q : act_blink_q;
        act_dp_d    = commit ? sh_dp_q    : act_dp_q;
        bcnt_d      = bcnt_q;
        phase_d     = phase_q;
        if (commit) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
            end
        end
        code_n  = act_codes_d[int'(idx_d) * 3 +: 3];
        blanked = phase_d && act_blink_d[idx_d];
        seg_d   = blanked ? 7'h7F : GLYPH[code_n];
        segp_d  = blanked ? 1'b1  : ~act_dp_d[idx_d];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_BLANK;
            idx_q       <= '0;
            bcnt_q      <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            sh_codes_q  <= '0;
            sh_blink_q  <= '0;
            sh_dp_q     <= '0;
            act_codes_q <= '0;
            act_blink_q <= '0;
            act_dp_q    <= '0;
            seg_q       <= 7'h7F;
            segp_q      <= 1'b1;
            dig_q       <= 4'hF;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            act_codes_q <= act_codes_d;
            act_blink_q <= act_blink_d;
            act_dp_q    <= act_dp_d;
            ack_q       <= accept;
            frame_q     <= 1'b0;
            if (accept) begin
                sh_codes_q <= CODES;
                sh_blink_q <= BLINK;
                sh_dp_q    <= DP;
            end
            case (state_q)
                S_BLANK: begin
                    state_q <= S_DRIVE;
                    dig_q   <= ~(4'b0001 << idx_q);
                end
                S_DRIVE: begin
                    // All enables off for one cycle while segments switch digit
                    if (tick) begin
                        state_q <= S_BLANK;
                        dig_q   <= 4'hF;
                        seg_q   <= seg_d;
                        segp_q  <= segp_d;
                        frame_q <= commit;
                    end
                end
                default: state_q <= S_BLANK;
            endcase
        end
    end

    assign ACK    = ack_q;
    assign FRAME  = frame_q;
    assign SEGs   = seg_q;
    assign SEG_P  = segp_q;
    assign SEG_D1 = dig_q[0];
    assign SEG_D2 = dig_q[1];
    assign SEG_D3 = dig_q[2];
    assign SEG_D4 = dig_q[3];
endmodule

// File: tb/tb_mostrador_varredura.sv
// Bench for mostrador_varredura with PRESC=4, BLINK_FRAMES=2: directed and random
// offers checked every cycle against a frame/slot timing model of the display.
module tb_mostrador_varredura;
    localparam int P    = 4;
    localparam int BF   = 2;
    localparam int FLEN = 4 * P;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] CODES = '0;
    logic [3:0]  BLINK = '0;
    logic [3:0]  DP = '0;
    logic        LOAD = 1'b0;
    logic        ACK, FRAME, SEG_P, SEG_D1, SEG_D2, SEG_D3, SEG_D4;
    logic [6:0]  SEGs;

    mostrador_varredura #(.PRESC(P), .BLINK_FRAMES(BF)) dut (
        .CLK(CLK), .RST(RST), .CODES(CODES), .BLINK(BLINK), .DP(DP), .LOAD(LOAD),
        .ACK(ACK), .FRAME(FRAME), .SEGs(SEGs), .SEG_P(SEG_P),
        .SEG_D1(SEG_D1), .SEG_D2(SEG_D2), .SEG_D3(SEG_D3), .SEG_D4(SEG_D4)
    );

    always #5 CLK = ~CLK;

    logic [6:0] glyph_tab [0:7] = '{7'h7F, 7'h47, 7'h09, 7'h08, 7'h06, 7'h0C, 7'h41, 7'h3F};

    int checks = 0;
    int passes = 0;

    // Model: n = cycles since the reset edge; offers held in a shadow until frame end
    int          n = 0;
    logic        m_pend = 1'b0;
    logic        m_ack = 1'b0;
    logic [11:0] sh_c = '0, act_c = '0;
    logic [3:0]  sh_b = '0, act_b = '0, sh_d = '0, act_d = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [11:0] exp_disp();
        int pos, d, f;
        logic ph, blank;
        logic [2:0] code;
        logic [3:0] one;
        logic [3:0] dig;
        pos   = n % P;
        d     = (n / P) % 4;
        f     = n / FLEN;
        ph    = ((f / BF) % 2) == 1;
        blank = ph && act_b[d];
        code  = act_c[d*3 +: 3];
        one   = 4'b0001;
        dig   = (pos == 0) ? 4'hF : ~(one << d);
        return {blank ? 7'h7F : glyph_tab[code], blank ? 1'b1 : ~act_d[d], dig};
    endfunction

    task automatic step();
        logic commit, acc;
        if (RST) begin
            n = 0; m_pend = 0; m_ack = 0;
            sh_c = '0; sh_b = '0; sh_d = '0; act_c = '0; act_b = '0; act_d = '0;
        end else begin
            commit = (n % FLEN) == FLEN - 1;
            if (commit) begin
                act_c = sh_c; act_b = sh_b; act_d = sh_d; m_pend = 0;
            end
            acc = LOAD && !m_pend;
            if (acc) begin
                sh_c = CODES; sh_b = BLINK; sh_d = DP; m_pend = 1;
            end
            m_ack = acc;
            n++;
        end
        @(posedge CLK);
        #1;
        chk("display", {4'b0, SEGs, SEG_P, SEG_D4, SEG_D3, SEG_D2, SEG_D1}, {4'b0, exp_disp()});
        chk("ack_frame", {14'b0, ACK, FRAME},
            {14'b0, m_ack, (n % FLEN == 0) && (n > 0)});
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_pos(input int m);
        int b;
        b = 0;
        while ((n % FLEN) != m && b < 2 * FLEN) begin step(); b++; end
        if ((n % FLEN) != m) begin
            checks++;
            $error("FAIL wait_pos: observed position %0d expected %0d", n % FLEN, m);
        end
    endtask

    task automatic offer(input logic [11:0] c, input logic [3:0] b, input logic [3:0] d);
        int t;
        CODES = c; BLINK = b; DP = d; LOAD = 1'b1;
        t = 0;
        step();
        while (ACK !== 1'b1 && t < 3 * FLEN) begin step(); t++; end
        if (ACK !== 1'b1) begin
            checks++;
            $error("FAIL offer_timeout: observed ACK %b expected 1", ACK);
        end
        LOAD = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        run(3);
        chk("reset_segs", {9'b0, SEGs}, 16'h007F);
        chk("reset_dig", {12'b0, SEG_D4, SEG_D3, SEG_D2, SEG_D1}, 16'h000F);
        RST = 1'b0;
        run(2 * FLEN + 5);

        // Fixed pattern L/H/U/- with decimal point on digit 0
        wait_pos(4);
        offer(12'b111_110_010_001, 4'b0000, 4'b0001);
        wait_pos(2);
        chk("d1_glyph", {8'b0, SEGs, SEG_P}, {8'b0, 7'h47, 1'b0});
        chk("d1_en", {12'b0, SEG_D4, SEG_D3, SEG_D2, SEG_D1}, 16'h000E);
        wait_pos(6);
        chk("d2_glyph", {9'b0, SEGs}, 16'h0009);
        wait_pos(10);
        chk("d3_glyph", {9'b0, SEGs}, 16'h0041);
        wait_pos(14);
        chk("d4_glyph", {9'b0, SEGs}, 16'h003F);

        // Offer accepted, then a second one held across the commit
        wait_pos(3);
        offer({$urandom} [11:0], 4'b0000, {$urandom} [3:0]);
        offer({$urandom} [11:0], 4'b0000, {$urandom} [3:0]);
        run(2 * FLEN);

        // Random offers with random idle gaps
        for (int k = 0; k < 8; k++) begin
            run($urandom_range(0, 20));
            offer({$urandom} [11:0], {$urandom} [3:0], {$urandom} [3:0]);
        end
        run(2 * FLEN);

        // Blink on digit 1 showing 'A'
        offer({3'd4, 3'd1, 3'd3, 3'd2}, 4'b0010, 4'b0000);
        run(5 * FLEN);

        // Reset while D3 is driven and an offer is pending
        wait_pos(1);
        offer({$urandom} [11:0], {$urandom} [3:0], {$urandom} [3:0]);
        wait_pos(10);
        RST = 1'b1;
        step();
        chk("rst_mid_ack", {15'b0, ACK}, 16'h0000);
        chk("rst_mid_dig", {12'b0, SEG_D4, SEG_D3, SEG_D2, SEG_D1}, 16'h000F);
        RST = 1'b0;
        run(2 * FLEN);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
